led_scan: RTL

LED_SCAN -- requirements
Module: led_scan

---
 rtl/led_scan.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/led_scan.sv
// Multiplexed 7-segment scanner: hex decode, leading-zero blank, blink, anti-ghost guard slot.
// Latency: outputs registered, one cycle behind prescaler/index. No backpressure; free-running scan.
module led_scan #(
    parameter int DIGITS    = 4,
    parameter int DIV       = 50000,
    parameter int BLINK_DIV = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  n_en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     n_dig,
    output logic                  frame
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = $clog2(BLINK_DIV + 1);

    function automatic logic [6:0] f_hex(input logic [3:0] n);
        case (n)
            4'h0: f_hex = 7'h7E;
            4'h1: f_hex = 7'h30;
            4'h2: f_hex = 7'h6D;
            4'h3: f_hex = 7'h79;
            4'h4: f_hex = 7'h33;
            4'h5: f_hex = 7'h5B;
            4'h6: f_hex = 7'h5F;
            4'h7: f_hex = 7'h70;
            4'h8: f_hex = 7'h7F;
            4'h9: f_hex = 7'h7B;
            4'hA: f_hex = 7'h77;
            4'hB: f_hex = 7'h1F;
            4'hC: f_hex = 7'h0D;
            4'hD: f_hex = 7'h3D;
            4'hE: f_hex = 7'h6F;
            default: f_hex = 7'h47;
        endcase
    endfunction

    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;
    logic [BW-1:0]       r_bcnt;
    logic                r_phase;
    logic [4*DIGITS-1:0] r_pend_data, r_sh_data;
    logic [DIGITS-1:0]   r_pend_dp, r_sh_dp;
    logic [DIGITS-1:0]   r_pend_blink, r_sh_blink;

    logic                w_pre_last, w_wrap;
    logic [3:0]          w_nib;
    logic                w_dp_bit, w_blk_bit, w_upper_zero, w_lz_blank;
    logic [DIGITS-1:0]   w_sel;
    logic [6:0]          w_seg;
    logic                w_seg_dp;
    logic [DIGITS-1:0]   w_n_dig;

    assign w_pre_last = (r_pre == PW'(DIV - 1));
    assign w_wrap     = w_pre_last && (r_idx == IW'(DIGITS - 1));

    always_comb begin
        w_nib        = 4'h0;
        w_dp_bit     = 1'b0;
        w_blk_bit    = 1'b0;
        w_sel        = '1;
        w_upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == r_idx) begin
                w_nib     = r_sh_data[4*i +: 4];
                w_dp_bit  = r_sh_dp[i];
                w_blk_bit = r_sh_blink[i];
                w_sel[i]  = 1'b0;
            end
            if (IW'(i) >= r_idx && r_sh_data[4*i +: 4] != 4'h0)
                w_upper_zero = 1'b0;
        end
        w_lz_blank = blank_lz && (r_idx != '0) && w_upper_zero;

        w_seg    = 7'h00;
        w_seg_dp = 1'b0;
        w_n_dig  = '1;
        // Prescaler 0 is the dark guard slot that lets the digit drivers turn off before the next select.
        if (!n_en && r_pre != '0) begin
            w_n_dig = w_sel;
            if (!(r_phase && w_blk_bit)) begin
                w_seg    = w_lz_blank ? 7'h00 : f_hex(w_nib);
                w_seg_dp = w_dp_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_bcnt       <= '0;
            r_phase      <= 1'b0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blink <= '0;
            r_sh_data    <= '0;
            r_sh_dp      <= '0;
            r_sh_blink   <= '0;
            seg          <= 7'h00;
            seg_dp       <= 1'b0;
            n_dig        <= '1;
            frame        <= 1'b0;
        end else begin
            r_pre <= w_pre_last ? '0 : r_pre + 1'b1;
            if (w_pre_last)
                r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

            if (load) begin
                r_pend_data  <= data;
                r_pend_dp    <= dp;
                r_pend_blink <= blink;
            end

            if (w_wrap) begin
                // A load coinciding with the wrap bypasses pending so it is not lost for a frame.
                r_sh_data  <= load ? data  : r_pend_data;
                r_sh_dp    <= load ? dp    : r_pend_dp;
                r_sh_blink <= load ? blink : r_pend_blink;
                if (r_bcnt == BW'(BLINK_DIV - 1)) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end

            seg    <= w_seg;
            seg_dp <= w_seg_dp;
            n_dig  <= w_n_dig;
            frame  <= w_wrap;
        end
    end

endmodule
